// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state encoding and sizing constants for the LCM engine
package arith_pkg;
  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} lcm_state_t;
  localparam int LCM_N = 8;
  localparam int DIV_CNT_W = $clog2(LCM_N);
endpackage

// File: rtl/gcd_iter.sv
// gcd_iter: registered subtraction-loop GCD, one Euclid step per cycle
module gcd_iter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] g
);
  logic [N-1:0] ra, rb;
  // load on start (zero operands never start, the loop would not terminate); then subtract smaller from larger
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= '0;
      rb <= '0;
      busy <= 1'b0;
    end else if (start) begin
      ra <= a;
      rb <= b;
      busy <= (a != '0) && (b != '0);
    end else if (busy) begin
      if (ra > rb) ra <= ra - rb;
      else if (rb > ra) rb <= rb - ra;
      else busy <= 1'b0;
    end
  assign done = busy && (ra == rb);
  assign g = ra;
endmodule

// File: rtl/lcm_calculator.sv
// lcm_calculator: handshaked multi-cycle LCM/GCD engine, lcm = (a / gcd) * b
module lcm_calculator
  import arith_pkg::*;
#(
  parameter int N = LCM_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] lcm,
  output logic [N-1:0]   hcf
);
  localparam int W2 = 2 * N;
  lcm_state_t state, nxt;
  logic [N-1:0] dq, ob, g, rem, gcd_g;
  logic [DIV_CNT_W-1:0] cnt;
  logic [N:0] trial, diff;
  logic accept, zero, gcd_busy, gcd_done;
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept = in_valid && in_ready;
  assign zero = (in1 == '0) || (in2 == '0);
  assign trial = {rem, dq[N-1]};
  assign diff = trial - {1'b0, g};
  gcd_iter #(.N(N)) u_gcd (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept && !zero),
    .a    (in1),
    .b    (in2),
    .busy (gcd_busy),
    .done (gcd_done),
    .g    (gcd_g)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: zero operands short-circuit to DONE, otherwise GCD -> DIV -> MUL -> DONE
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? (zero ? DONE : GCD) : IDLE;
      GCD:  nxt = gcd_done ? DIV : (gcd_busy ? GCD : IDLE);
      DIV:  nxt = (cnt == DIV_CNT_W'(N - 1)) ? MUL : DIV;
      MUL:  nxt = DONE;
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // datapath: dq holds oa and shifts quotient bits in as the restoring divider consumes dividend bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dq <= '0;
      ob <= '0;
      g <= '0;
      rem <= '0;
      cnt <= '0;
      lcm <= '0;
      hcf <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dq <= in1;
          ob <= in2;
          if (zero) begin
            lcm <= '0;
            hcf <= in1 | in2;
          end
        end
        GCD: if (gcd_done) begin
          g <= gcd_g;
          rem <= '0;
          cnt <= '0;
        end
        DIV: begin
          rem <= diff[N] ? trial[N-1:0] : diff[N-1:0];
          dq <= {dq[N-2:0], ~diff[N]};
          cnt <= cnt + 1'b1;
        end
        MUL: begin
          lcm <= W2'(dq) * W2'(ob);
          hcf <= g;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_lcm_calculator.sv
// tb_lcm_calculator: directed and random checks of lcm_calculator against an arithmetic model
module tb_lcm_calculator;
  localparam int N = 8;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic [N-1:0] in1 = '0, in2 = '0;
  logic in_ready, out_valid;
  logic [2*N-1:0] lcm;
  logic [N-1:0] hcf;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lcm_calculator #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .lcm(lcm), .hcf(hcf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // subtraction steps of Euclid equal the sum of modulo-Euclid quotients, minus the final equal step
  function automatic int sub_steps(input int a, input int b);
    int s, t;
    s = 0;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s - 1;
  endfunction

  task automatic do_pair(input int x, input int y, input int hold, input bit rnd);
    int t, lat, g, exp_lat;
    longint exp_l;
    g = ref_gcd(x, y);
    exp_l = (g == 0) ? 0 : longint'(x) * longint'(y) / g;
    exp_lat = (x == 0 || y == 0) ? 0 : sub_steps(x, y) + N + 2;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", t < 300, 1);
    in1 = N'(x);
    in2 = N'(y);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    if (rnd) begin
      in1 = N'($urandom);
      in2 = N'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < 600) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in1 = N'($urandom);
        in2 = N'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    out_ready = 0;
    chk("out_valid_seen", out_valid, 1);
    chk("latency", lat, exp_lat);
    chk("hcf", hcf, g);
    chk("lcm", lcm, exp_l);
    chk("in_ready_busy", in_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_lcm", lcm, exp_l);
      chk("bp_hcf", hcf, g);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("lcm_retained", lcm, exp_l);
  endtask

  initial begin
    int px[5], py[5];
    px = '{56, 49, 108, 17, 100};
    py = '{84, 77, 24, 103, 70};
    #1 rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lcm", lcm, 0);
    chk("rst_hcf", hcf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_pair(27, 45, 0, 0);
    for (int i = 0; i < 5; i++) do_pair(px[i], py[i], 0, 0);
    do_pair(255, 254, 0, 0);
    do_pair(255, 255, 0, 0);
    do_pair(0, 45, 0, 0);
    do_pair(0, 0, 0, 0);
    do_pair(56, 84, 20, 0);
    in1 = 17;
    in2 = 103;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_lcm", lcm, 0);
    chk("abort_hcf", hcf, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 0);
    end
    do_pair(27, 45, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      int x, y;
      x = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 255));
      y = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_pair(x, y, int'($urandom_range(0, 3)), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcm_calculator.md
Name: lcm_calculator

Overview:
- Multi-cycle, handshaked least-common-multiple engine for two unsigned N-bit operands.
- Computes GCD iteratively, divides one operand by the GCD, then multiplies by the other: LCM = (a / gcd) * b.
- Reports both the LCM (2N bits) and the GCD (N bits).
- Sequential counterpart to the combinational highest-common-factor block; it sits behind a producer/consumer valid/ready pair in the arithmetic datapath.

Parameters:
- N, 8, operand width in bits; LCM result is 2N bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- in1  input  N  first operand, unsigned
- in2  input  N  second operand, unsigned
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- lcm  output  2N  least common multiple of the captured operands
- hcf  output  N  greatest common divisor of the captured operands

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; lcm=0; hcf=0; all internal registers cleared.
- Reset asserted mid-operation aborts the computation immediately; no result is ever presented for the aborted pair.
- FSM states: IDLE, GCD, DIV, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a=in1, b=in2, keep the original copies oa, ob.
  - If in1==0 or in2==0, go to DONE with lcm=0 and hcf=in1|in2 (gcd(0,0)=0).
  - Otherwise go to GCD.
- GCD (Euclid by subtraction, one step per cycle):
  - if a>b: a<=a-b; if b>a: b<=b-a.
  - When a==b on entry to the cycle: g<=a, go to DIV.
  - Cycles in GCD are data-dependent; bounded by 2^N-1.
- DIV:
  - Restoring division oa/g, one quotient bit per cycle, MSB first.
  - Exactly N cycles, counter counts 0..N-1.
  - Remainder is guaranteed 0 and is not checked.
  - Then go to MUL.
- MUL:
  - Single cycle: lcm<=q*ob, with q and ob zero-extended to 2N bits; product is exact since lcm ≤ (2^N-1)^2.
  - hcf<=g; go to DONE.
- DONE:
  - out_valid=1; lcm and hcf held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - lcm and hcf retain their last values in IDLE.
- Throughput: one pair in flight. in_ready is low from the acceptance cycle until the cycle after the result handshake.
- Latency (acceptance edge to out_valid high):
  - 1 cycle for a zero operand.
  - Otherwise (GCD steps+1) + N + 1 cycles.
  - Example: in1=in2=5 gives 1+N+1 = 10 cycles for N=8.
- in1/in2 changes outside the acceptance cycle are ignored.
- in_valid held high while busy is not consumed until IDLE.

Decomposition:
- Shared package arith_pkg:
  - FSM state enum (IDLE, GCD, DIV, MUL, DONE).
  - Localparam for the division counter width, $clog2(N).
- One natural sub-module, gcd_iter: the subtraction-loop GCD.
  - Ports: start, a, b, busy, done, g.
  - Reusable by the existing HCF consumers that need a registered, small-area version.
- Divider and multiplier stay inline in lcm_calculator.

Test Plan:
- in1=27, in2=45, out_ready=1 -> hcf=9, lcm=135; one out_valid pulse; in_ready returns high the following cycle.
- Sequential pairs (56,84), (49,77), (108,24), (17,103), (100,70) -> hcf/lcm = 28/168, 7/539, 12/216, 1/1751, 10/700.
  - Check every pair against a reference model using gcd and a*b/gcd.
- Boundary operands:
  - (255,254) -> hcf=1, lcm=64770 (full 2N width).
  - (255,255) -> hcf=255, lcm=255; latency exactly 10 cycles.
  - (0,45) -> hcf=45, lcm=0, out_valid 1 cycle after acceptance.
  - (0,0) -> hcf=0, lcm=0.
- Backpressure: (56,84) with out_ready=0 for 20 cycles -> out_valid stays high, lcm=168/hcf=28 stable, in_ready=0; raise out_ready -> single transfer, return to IDLE.
- Reset mid-op:
  - Pair (17,103); assert rst_n=0 during GCD -> outputs clear asynchronously, in_ready=1 after release.
  - Next pair (27,45) -> 135/9; no stale result appears.
- Random soak: 1000 random N=8 pairs with random in_valid/out_ready toggling -> every result matches the model and no handshake is lost or duplicated.
